// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage normalisation of the raw adder mantissa with exponent adjust and valid/ready flow control
module fp_norm_pipe #(
    parameter int SIZE_DATA = 28,
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_LOPD = $clog2(SIZE_DATA)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_zero_flag,
    input  logic                 i_sign,
    input  logic [SIZE_EXP-1:0]  i_exponent,
    input  logic [SIZE_DATA-1:0] i_mantissa,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign,
    output logic [SIZE_EXP-1:0]  o_exponent,
    output logic [SIZE_DATA-1:0] o_mantissa,
    output logic                 o_zero,
    output logic                 o_underflow,
    output logic                 o_overflow
);
    logic                 s1_valid, s1_sign, s1_zero, s1_carry;
    logic [SIZE_EXP-1:0]  s1_exp;
    logic [SIZE_DATA-1:0] s1_mant;
    logic [SIZE_LOPD-1:0] s1_lz, lz;
    logic                 s2_valid, s2_adv;
    logic [SIZE_EXP:0]    exp_w, lz_w, exp_inc;
    logic [SIZE_EXP-1:0]  dn_sh, n_exp;
    logic [SIZE_DATA-1:0] cy_mant, nm_mant, dn_mant, n_mant;
    logic                 cy_of, is_norm, n_uf, n_of;

    assign s2_adv  = ~s2_valid | i_ready;
    assign o_ready = ~s1_valid | s2_adv;
    assign o_valid = s2_valid;

    // Leading-zero count below the carry bit; the highest set bit wins
    always_comb begin
        lz = SIZE_LOPD'(SIZE_DATA - 1);
        for (int i = 0; i < SIZE_DATA - 1; i++)
            if (i_mantissa[i]) lz = SIZE_LOPD'(SIZE_DATA - 2 - i);
    end

    // Stage 1: capture the beat with its zero, carry and leading-zero classification
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_carry <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_lz    <= '0;
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sign  <= i_sign;
                s1_zero  <= i_zero_flag | (i_mantissa == '0);
                s1_carry <= i_mantissa[SIZE_DATA-1];
                s1_exp   <= i_exponent;
                s1_mant  <= i_mantissa;
                s1_lz    <= lz;
            end
        end
    end

    // Normalisation in priority order: zero, carry right-shift, left-normalise, denormal clamp
    always_comb begin
        exp_w   = {1'b0, s1_exp};
        lz_w    = (SIZE_EXP+1)'(s1_lz);
        exp_inc = exp_w + (SIZE_EXP+1)'(1);
        cy_of   = exp_inc >= {1'b0, {SIZE_EXP{1'b1}}};
        cy_mant = {1'b0, s1_mant[SIZE_DATA-1:2], |s1_mant[1:0]};
        is_norm = exp_w > lz_w;
        nm_mant = s1_mant << s1_lz;
        dn_sh   = (s1_exp == '0) ? '0 : s1_exp - SIZE_EXP'(1);
        dn_mant = s1_mant << dn_sh;
        n_mant  = s1_zero ? '0 : s1_carry ? (cy_of ? '0 : cy_mant) : is_norm ? nm_mant : dn_mant;
        n_exp   = s1_zero ? '0 : s1_carry ? (cy_of ? '1 : exp_inc[SIZE_EXP-1:0]) :
                  is_norm ? SIZE_EXP'(exp_w - lz_w) : '0;
        n_uf    = ~s1_zero & ~s1_carry & ~is_norm & ~dn_mant[SIZE_DATA-2];
        n_of    = ~s1_zero & s1_carry & cy_of;
    end

    // Stage 2: register the normalised result; holds while downstream stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid    <= 1'b0;
            o_sign      <= 1'b0;
            o_exponent  <= '0;
            o_mantissa  <= '0;
            o_zero      <= 1'b0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_sign      <= s1_sign;
                o_exponent  <= n_exp;
                o_mantissa  <= n_mant;
                o_zero      <= s1_zero;
                o_underflow <= n_uf;
                o_overflow  <= n_of;
            end
        end
    end
endmodule
